// File: rtl/sopc_cpu_ocimem_scheduler.sv
// OCI debug RAM scheduler: JTAG debug slave vs CPU monitor port.
// Define OCIMEM_PROTECT_EN to reject CPU writes at or above PROTECT_BASE.
module sopc_cpu_ocimem_scheduler #(
   parameter int                ADDR_W       = 8,
   parameter logic [ADDR_W-1:0] PROTECT_BASE = ADDR_W'(8'hE0)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);
   typedef enum logic [2:0] {
      IDLE, JWR, JRD, JRD_WAIT, CRD_WAIT
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] jaddr_q;
   logic              pend_q;
   logic              pend_wr_q;
   logic              pend_inc_q;
   logic [31:0]       pend_data_q;
   logic              last_jtag_q;
   logic              cpu_gnt_q;
   logic              cpu_rvalid_q;
   logic              cpu_err_q;
   logic              ram_en_q;
   logic              ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [31:0]       ram_wdata_q;
   logic [31:0]       mon_q;
   logic              mon_rdy_q;
   logic              mon_err_q;

   logic pa, pb, pn;
   logic busy_d, acc_a_d, acc_b_d, acc_n_d;
   logic drop_d, new_pend_d, clr_d;
   logic cpu_cand_d, tie_d;
   logic pick_j_d, pick_c_d, blocked_d;
   logic unused_ok;

   assign pa = take_action_ocimem_a;
   assign pb = take_action_ocimem_b;
   assign pn = take_no_action_ocimem_a;

   // Sort this cycle's pulses into accepted and dropped ones.
   always_comb begin
      busy_d = pend_q
             | (state_q == JWR)
             | (state_q == JRD)
             | (state_q == JRD_WAIT);
      acc_a_d = pa & ~busy_d;
      acc_b_d = pb & ~pa & ~busy_d;
      acc_n_d = pn & ~pa & ~pb & ~busy_d;
      drop_d = ((pa | pb | pn) & busy_d)
             | (pa & (pb | pn))
             | (pb & pn);
      clr_d = acc_a_d & jdo[1];
      new_pend_d = (acc_a_d & jdo[0])
                 | acc_b_d | acc_n_d;
   end

   // Round-robin pick; the pointer only moves on a real tie.
   always_comb begin
      cpu_cand_d = cpu_req & ~cpu_gnt_q;
      tie_d = pend_q & cpu_cand_d;
      pick_j_d = pend_q
               & (~cpu_cand_d | ~last_jtag_q);
      pick_c_d = cpu_cand_d & ~pick_j_d;
`ifdef OCIMEM_PROTECT_EN
      blocked_d = cpu_we
                & (cpu_addr >= PROTECT_BASE);
`else
      blocked_d = 1'b0;
`endif
   end

   // Command slot, status flags and the RAM sequencing FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         jaddr_q      <= '0;
         pend_q       <= 1'b0;
         pend_wr_q    <= 1'b0;
         pend_inc_q   <= 1'b0;
         pend_data_q  <= '0;
         last_jtag_q  <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         cpu_err_q    <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         mon_q        <= '0;
         mon_rdy_q    <= 1'b1;
         mon_err_q    <= 1'b0;
      end else begin
         cpu_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         cpu_err_q    <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         if (clr_d)
            mon_err_q <= 1'b0;
         if (drop_d)
            mon_err_q <= 1'b1;
         if (acc_a_d)
            jaddr_q <= jdo[ADDR_W+1:2];
         if (new_pend_d) begin
            pend_q      <= 1'b1;
            pend_wr_q   <= acc_b_d;
            pend_inc_q  <= acc_b_d | acc_n_d;
            pend_data_q <= jdo[34:3];
            mon_rdy_q   <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (tie_d)
                  last_jtag_q <= pick_j_d;
               if (pick_j_d) begin
                  pend_q      <= 1'b0;
                  ram_en_q    <= 1'b1;
                  ram_we_q    <= pend_wr_q;
                  ram_addr_q  <= jaddr_q;
                  ram_wdata_q <= pend_data_q;
                  state_q     <= pend_wr_q ? JWR : JRD;
               end else if (pick_c_d) begin
                  cpu_gnt_q   <= 1'b1;
                  cpu_err_q   <= blocked_d;
                  ram_en_q    <= ~blocked_d;
                  ram_we_q    <= cpu_we & ~blocked_d;
                  ram_addr_q  <= cpu_addr;
                  ram_wdata_q <= cpu_wdata;
                  if (!cpu_we)
                     state_q <= CRD_WAIT;
               end
            end
            JWR: begin
               jaddr_q   <= jaddr_q + ADDR_W'(1);
               mon_rdy_q <= 1'b1;
               state_q   <= IDLE;
            end
            JRD: begin
               state_q <= JRD_WAIT;
            end
            JRD_WAIT: begin
               mon_q     <= ram_rdata;
               mon_rdy_q <= 1'b1;
               if (pend_inc_q)
                  jaddr_q <= jaddr_q + ADDR_W'(1);
               state_q   <= IDLE;
            end
            CRD_WAIT: begin
               cpu_rvalid_q <= 1'b1;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_gnt       = cpu_gnt_q;
   assign cpu_rvalid    = cpu_rvalid_q;
   assign cpu_rdata     = cpu_rvalid_q ? ram_rdata : '0;
   assign cpu_err       = cpu_err_q;
   assign ram_en        = ram_en_q;
   assign ram_we        = ram_we_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;
   assign MonDReg       = mon_q;
   assign monitor_ready = mon_rdy_q;
   assign monitor_error = mon_err_q;
   assign unused_ok     = ^{jdo[37:35], PROTECT_BASE};
endmodule

// File: tb/tb_sopc_cpu_ocimem_scheduler.sv
// Bench for sopc_cpu_ocimem_scheduler: vector table, corner sequences,
// random traffic against a memory/address reference model.
module tb_sopc_cpu_ocimem_scheduler;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [37:0] jdo = '0;
   logic        ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [7:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_gnt, cpu_rvalid, cpu_err;
   logic [31:0] cpu_rdata;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;

`ifdef OCIMEM_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] ram [256];
   bit          wr_done [256];
   logic [31:0] ref_mem [256];
   int          ref_jaddr;

   always #5 clk = ~clk;

   sopc_cpu_ocimem_scheduler dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(ta_a),
      .take_action_ocimem_b(ta_b),
      .take_no_action_ocimem_a(tn_a),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .MonDReg(MonDReg),
      .monitor_ready(monitor_ready),
      .monitor_error(monitor_error)
   );

   function automatic logic [31:0] init_val(input int a);
      logic [7:0] b;
      b = a[7:0];
      if (b == 8'h10) return 32'hDEADBEEF;
      if (b == 8'hFF) return 32'hFEEDF00D;
      return {24'hC0FFEE, b};
   endfunction

   // Synchronous single-port RAM, read data one cycle after ram_en.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram[ram_addr]     <= ram_wdata;
            wr_done[ram_addr] <= 1'b1;
         end else begin
            ram_rdata <= wr_done[ram_addr] ? ram[ram_addr]
                                           : init_val(int'(ram_addr));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // op 0: ocimem_a, 1: ocimem_b, 2: no_action_a
   task automatic jtag(input int op, input logic [7:0] addr,
                       input logic rd, input logic clr,
                       input logic [31:0] data, output int lat,
                       output logic [7:0] aaddr, output logic awe,
                       output logic aseen);
      jdo = '0;
      if (op == 1) jdo[34:3] = data;
      else begin
         jdo[9:2] = addr;
         jdo[0]   = rd;
         jdo[1]   = clr;
      end
      ta_a = (op == 0);
      ta_b = (op == 1);
      tn_a = (op == 2);
      tick();
      ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
      lat = 1; aseen = 1'b0; aaddr = '0; awe = 1'b0;
      while (!monitor_ready && lat < 20) begin
         if (ram_en && !cpu_gnt) begin
            aseen = 1'b1; aaddr = ram_addr; awe = ram_we;
         end
         tick();
         lat++;
      end
   endtask

   task automatic cpu_acc(input logic we, input logic [7:0] a,
                          input logic [31:0] d, output int ngnt,
                          output logic err, output logic en,
                          output logic [31:0] rd, output int dk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      ngnt = 0; err = 1'b0; en = 1'b0; rd = '0; dk = -1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (cpu_gnt) begin
            ngnt++; err = cpu_err; en = ram_en; cpu_req = 1'b0;
         end
         if (cpu_rvalid) begin
            rd = cpu_rdata; dk = k;
         end
      end
      cpu_req = 1'b0;
   endtask

   task automatic collide(input logic [7:0] ja, input logic [7:0] ca,
                          output int jk, output int ck,
                          output logic [31:0] crd);
      jdo = '0; jdo[9:2] = ja; jdo[0] = 1'b1; ta_a = 1'b1;
      tick();
      ta_a = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
      jk = -1; ck = -1; crd = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (cpu_gnt && ck < 0) begin
            ck = k; cpu_req = 1'b0;
         end else if (ram_en && jk < 0) jk = k;
         if (cpu_rvalid) crd = cpu_rdata;
      end
      cpu_req = 1'b0;
   endtask

   typedef struct {
      int         op;
      logic [7:0] addr;
      logic       rd;
      logic [31:0] data;
      logic [7:0] eaddr;
      logic       ewe;
      int         elat;
      logic [31:0] emon;
   } vec_t;

   vec_t tv [10];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ng, dk, jk, ck, cnt, sel;
      logic [7:0] aa, a;
      logic we, seen, er, en;
      logic [31:0] rd, d;

      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

      tv[0] = '{0, 8'h10, 1'b1, 32'h0, 8'h10, 1'b0, 4, 32'hDEADBEEF};
      tv[1] = '{1, 8'h00, 1'b0, 32'h11111111, 8'h10, 1'b1, 3, 32'hDEADBEEF};
      tv[2] = '{1, 8'h00, 1'b0, 32'h22222222, 8'h11, 1'b1, 3, 32'hDEADBEEF};
      tv[3] = '{2, 8'h00, 1'b0, 32'h0, 8'h12, 1'b0, 4, 32'hC0FFEE12};
      tv[4] = '{0, 8'h10, 1'b1, 32'h0, 8'h10, 1'b0, 4, 32'h11111111};
      tv[5] = '{2, 8'h00, 1'b0, 32'h0, 8'h10, 1'b0, 4, 32'h11111111};
      tv[6] = '{2, 8'h00, 1'b0, 32'h0, 8'h11, 1'b0, 4, 32'h22222222};
      tv[7] = '{0, 8'hFF, 1'b0, 32'h0, 8'h00, 1'b0, 1, 32'h22222222};
      tv[8] = '{2, 8'h00, 1'b0, 32'h0, 8'hFF, 1'b0, 4, 32'hFEEDF00D};
      tv[9] = '{2, 8'h00, 1'b0, 32'h0, 8'h00, 1'b0, 4, 32'hC0FFEE00};

      repeat (3) @(posedge clk);
      #1;
      chk("rst cpu_gnt", {31'b0, cpu_gnt}, 0);
      chk("rst cpu_rvalid", {31'b0, cpu_rvalid}, 0);
      chk("rst cpu_err", {31'b0, cpu_err}, 0);
      chk("rst ram_en", {31'b0, ram_en}, 0);
      chk("rst ram_we", {31'b0, ram_we}, 0);
      chk("rst ram_addr", {24'b0, ram_addr}, 0);
      chk("rst ram_wdata", ram_wdata, 0);
      chk("rst cpu_rdata", cpu_rdata, 0);
      chk("rst MonDReg", MonDReg, 0);
      chk("rst ready", {31'b0, monitor_ready}, 1);
      chk("rst error", {31'b0, monitor_error}, 0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         jtag(tv[i].op, tv[i].addr, tv[i].rd, 1'b0, tv[i].data,
              lat, aa, we, seen);
         if (tv[i].op == 1) ref_mem[tv[i].eaddr] = tv[i].data;
         chk($sformatf("vec%0d latency", i), lat, tv[i].elat);
         if (tv[i].elat > 1) begin
            chk($sformatf("vec%0d addr", i), {24'b0, aa},
                {24'b0, tv[i].eaddr});
            chk($sformatf("vec%0d we", i), {31'b0, we},
                {31'b0, tv[i].ewe});
         end else begin
            chk($sformatf("vec%0d no access", i), {31'b0, seen}, 0);
         end
         chk($sformatf("vec%0d MonDReg", i), MonDReg, tv[i].emon);
         chk($sformatf("vec%0d error", i), {31'b0, monitor_error}, 0);
      end

      collide(8'h10, 8'h12, jk, ck, rd);
      chk("arb1 both served", {31'b0, (jk >= 0 && ck >= 0)}, 1);
      chk("arb1 jtag first", {31'b0, (jk < ck)}, 1);
      chk("arb1 cpu rdata", rd, ref_mem[8'h12]);
      chk("arb1 MonDReg", MonDReg, ref_mem[8'h10]);
      collide(8'h11, 8'hFF, jk, ck, rd);
      chk("arb2 both served", {31'b0, (jk >= 0 && ck >= 0)}, 1);
      chk("arb2 cpu first", {31'b0, (ck < jk)}, 1);
      chk("arb2 cpu rdata", rd, ref_mem[8'hFF]);
      chk("arb2 MonDReg", MonDReg, ref_mem[8'h11]);

      cpu_acc(1'b1, 8'hE5, 32'h5555AAAA, ng, er, en, rd, dk);
      chk("cpuE5 gnt", ng, 1);
      chk("cpuE5 err", {31'b0, er}, {31'b0, PROT});
      chk("cpuE5 ram_en", {31'b0, en}, {31'b0, ~PROT});
      if (!PROT) ref_mem[8'hE5] = 32'h5555AAAA;
      cpu_acc(1'b1, 8'hDF, 32'h1234ABCD, ng, er, en, rd, dk);
      chk("cpuDF gnt", ng, 1);
      chk("cpuDF err", {31'b0, er}, 0);
      ref_mem[8'hDF] = 32'h1234ABCD;
      jtag(0, 8'hE5, 1'b1, 1'b0, 0, lat, aa, we, seen);
      chk("cpuE5 readback", MonDReg, ref_mem[8'hE5]);
      cpu_acc(1'b0, 8'hDF, 0, ng, er, en, rd, dk);
      chk("cpuDF readback", rd, 32'h1234ABCD);
      chk("cpu read latency", dk, 1);

      jtag(0, 8'h40, 1'b0, 1'b0, 0, lat, aa, we, seen);
      jdo = '0; jdo[34:3] = 32'hAAAA0001; ta_b = 1'b1;
      tick();
      jdo[34:3] = 32'hBBBB0002;
      tick();
      ta_b = 1'b0;
      cnt = 0;
      while (!monitor_ready && cnt < 20) begin
         tick(); cnt++;
      end
      chk("ovr ready timeout", {31'b0, monitor_ready}, 1);
      chk("ovr error set", {31'b0, monitor_error}, 1);
      ref_mem[8'h40] = 32'hAAAA0001;
      jtag(2, 0, 1'b0, 1'b0, 0, lat, aa, we, seen);
      chk("ovr next addr", {24'b0, aa}, 32'h41);
      chk("ovr 0x41 untouched", MonDReg, ref_mem[8'h41]);
      jtag(0, 8'h40, 1'b1, 1'b0, 0, lat, aa, we, seen);
      chk("ovr first write", MonDReg, 32'hAAAA0001);
      chk("ovr error sticky", {31'b0, monitor_error}, 1);
      jtag(0, 8'h00, 1'b0, 1'b1, 0, lat, aa, we, seen);
      chk("ovr error clear", {31'b0, monitor_error}, 0);

      jdo = '0; jdo[9:2] = 8'h50; ta_a = 1'b1; tn_a = 1'b1;
      tick();
      ta_a = 1'b0; tn_a = 1'b0;
      chk("dual error", {31'b0, monitor_error}, 1);
      tick();
      chk("dual no op", {31'b0, monitor_ready}, 1);
      jtag(2, 0, 1'b0, 1'b0, 0, lat, aa, we, seen);
      chk("dual addr", {24'b0, aa}, 32'h50);
      chk("dual MonDReg", MonDReg, ref_mem[8'h50]);
      jtag(0, 8'h50, 1'b0, 1'b1, 0, lat, aa, we, seen);
      chk("dual clear", {31'b0, monitor_error}, 0);

      jdo = '0; jdo[9:2] = 8'h10; jdo[0] = 1'b1; ta_a = 1'b1;
      tick();
      ta_a = 1'b0;
      tick();
      chk("mid pre en", {31'b0, ram_en}, 1);
      reset_n = 1'b0;
      #1;
      chk("mid rst en", {31'b0, ram_en}, 0);
      chk("mid rst ready", {31'b0, monitor_ready}, 1);
      chk("mid rst MonDReg", MonDReg, 0);
      tick();
      reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (ram_en) cnt++;
      end
      chk("mid dropped", cnt, 0);
      jtag(2, 0, 1'b0, 1'b0, 0, lat, aa, we, seen);
      chk("mid jaddr reset", {24'b0, aa}, 0);
      chk("mid MonDReg", MonDReg, ref_mem[0]);

      a = 8'($urandom);
      jtag(0, a, 1'b0, 1'b0, 0, lat, aa, we, seen);
      ref_jaddr = int'(a);
      for (int i = 0; i < 120; i++) begin
         sel = int'($urandom_range(0, 4));
         a = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
         d = $urandom;
         case (sel)
            0: begin
               jtag(0, a, 1'b1, 1'b0, 0, lat, aa, we, seen);
               ref_jaddr = int'(a);
               chk("rnd A lat", lat, 4);
               chk("rnd A addr", {24'b0, aa}, {24'b0, a});
               chk("rnd A data", MonDReg, ref_mem[a]);
            end
            1: begin
               jtag(1, 0, 1'b0, 1'b0, d, lat, aa, we, seen);
               chk("rnd B lat", lat, 3);
               chk("rnd B addr", {24'b0, aa}, ref_jaddr);
               chk("rnd B we", {31'b0, we}, 1);
               ref_mem[ref_jaddr] = d;
               ref_jaddr = (ref_jaddr + 1) % 256;
            end
            2: begin
               jtag(2, 0, 1'b0, 1'b0, 0, lat, aa, we, seen);
               chk("rnd N lat", lat, 4);
               chk("rnd N data", MonDReg, ref_mem[ref_jaddr]);
               ref_jaddr = (ref_jaddr + 1) % 256;
            end
            3: begin
               cpu_acc(1'b1, a, d, ng, er, en, rd, dk);
               chk("rnd CW gnt", ng, 1);
               chk("rnd CW err", {31'b0, er},
                   {31'b0, (PROT && a >= 8'hE0)});
               if (!(PROT && a >= 8'hE0)) ref_mem[a] = d;
            end
            default: begin
               cpu_acc(1'b0, a, 0, ng, er, en, rd, dk);
               chk("rnd CR gnt", ng, 1);
               chk("rnd CR lat", dk, 1);
               chk("rnd CR data", rd, ref_mem[a]);
            end
         endcase
         chk("rnd error", {31'b0, monitor_error}, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sopc_cpu_ocimem_scheduler.md
Name: sopc_cpu_ocimem_scheduler

Overview:
- Sequences accesses to the on-chip debug memory (OCI RAM) in the Nios II CPU debug subsystem.
- Requesters: the JTAG debug slave, via its system-clock-side jdo and take_action_* pulses, and the CPU monitor port.
- Arbitrates the single-port RAM between them, tracks a JTAG auto-increment address, and captures read data into MonDReg with monitor_ready/monitor_error status for JTAG readback.

Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- PROTECT_BASE, 8'hE0, first word address protected from CPU writes (used only with OCIMEM_PROTECT_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data from debug slave (system-clock domain)
- take_action_ocimem_a  in  1  pulse: address load / optional read
- take_action_ocimem_b  in  1  pulse: write at current address
- take_no_action_ocimem_a  in  1  pulse: streaming read at current address
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_gnt  out  1  one-cycle grant
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- cpu_err  out  1  one-cycle pulse: CPU write rejected
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid 1 cycle after ram_en with ram_we=0
- MonDReg  out  32  JTAG read-data register
- monitor_ready  out  1  JTAG op complete / idle
- monitor_error  out  1  sticky: JTAG command overrun

Behaviour:
- Reset values: cpu_gnt, cpu_rvalid, cpu_err, ram_en, ram_we = 0; ram_addr, ram_wdata, cpu_rdata, MonDReg = 0; monitor_ready = 1; monitor_error = 0; JTAG address = 0; pending flag clear; FSM = IDLE. Reset mid-access aborts the access and drops any pending command.
- JTAG decode (one pending slot):
  - take_action_ocimem_a: jaddr <= jdo[ADDR_W+1:2]. If jdo[0]=1, a read at the new address becomes pending.
  - take_action_ocimem_b: pending write of jdo[34:3] at jaddr.
  - take_no_action_ocimem_a: pending read at jaddr.
- Accepting a command clears monitor_ready in the following cycle.
- Overrun: a command pulse while a command is pending or executing is dropped and sets monitor_error; the in-flight op continues. monitor_error clears only when take_action_ocimem_a arrives with jdo[1]=1 (that pulse's address/read fields still apply).
- Simultaneous pulses: priority ocimem_a > ocimem_b > no_action_a. Lower pulses are dropped and set monitor_error.
- FSM states: IDLE, JWR, JRD, JRD_WAIT, CRD_WAIT.
  - IDLE picks a requester. When both request, round-robin with the last-served pointer; JTAG wins the first tie after reset.
  - JTAG write: JWR drives ram_en=1, ram_we=1 for 1 cycle. Then jaddr <= jaddr+1 (mod 2^ADDR_W), monitor_ready <= 1, return to IDLE.
  - JTAG read: JRD drives ram_en=1, ram_we=0. JRD_WAIT captures MonDReg <= ram_rdata, sets monitor_ready, returns to IDLE.
  - Auto-increment applies to ocimem_b writes and no_action_a reads only. The jdo[0] read from ocimem_a does not increment.
  - CPU grant: cpu_gnt=1 for 1 cycle with ram_en driven from cpu_* in that same cycle. A write completes in that cycle. A read enters CRD_WAIT; next cycle cpu_rvalid=1, cpu_rdata=ram_rdata, then IDLE.
- Timing: JTAG op latency from pulse to monitor_ready is 3 cycles for a write and 4 for a read when uncontended. A CPU read returns 1 cycle after the grant.
- Address wrap: jaddr = 2^ADDR_W-1 increments to 0.
- ram_en deasserts in every state except JWR, JRD and the CPU grant cycle.

Optional Feature:
- OCIMEM_PROTECT_EN defined: a CPU write with cpu_addr >= PROTECT_BASE is still granted but ram_en stays 0, and cpu_err pulses for 1 cycle with cpu_gnt. JTAG writes are never blocked.
- Undefined: no check; cpu_err tied 0.

Test Plan:
- Reset, then take_action_ocimem_a with jdo[9:2]=8'h10, jdo[0]=1, RAM[0x10]=32'hDEADBEEF -> MonDReg=32'hDEADBEEF; monitor_ready low for 3 cycles and high 4 cycles after the pulse; jaddr stays 0x10.
- Two take_action_ocimem_b pulses (data 0x11111111, then 0x22222222), each after the previous monitor_ready -> RAM[0x10]=0x11111111, RAM[0x11]=0x22222222, jaddr=0x12.
- jaddr=0xFF, then take_no_action_ocimem_a -> reads RAM[0xFF], jaddr wraps to 0x00.
- cpu_req held while a JTAG read is pending, both arriving in IDLE -> JTAG served first, CPU granted next; repeat the collision -> CPU served first.
- Second ocimem_b pulse 1 cycle after the first -> monitor_error=1 and only the first write lands; ocimem_a with jdo[1]=1 -> monitor_error=0.
- With OCIMEM_PROTECT_EN: CPU write to 0xE5 -> cpu_gnt=1, cpu_err=1, RAM unchanged. CPU write to 0xDF -> written, cpu_err=0.
